rom_download_packer: RTL and testbench



---
 rtl/rom_download_packer.sv | 136 +++++++++++++
 tb/tb_rom_download_packer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_packer.sv
// Packs the byte-wide ioctl ROM download into 32-bit little-endian SDRAM words through a small FIFO.
// Optional ROM_CHECKSUM_EN adds a 16-bit running sum of every accepted download byte.
module rom_download_packer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        ioctl_download,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow,
`ifdef ROM_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic        dbg_state_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = AW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [3:0]    mask_q, mask_d;
  logic [22:0]   waddr_q, waddr_d;
  logic [31:0]   data_q, data_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          dl_q, busy_q, overflow_q;
  logic [54:0]   mem [FIFO_DEPTH];

  logic          push, fifo_wr, fifo_full, fifo_empty, pop;
  logic [3:0]    lane_sel;
  logic [31:0]   push_data;
  logic [54:0]   head;

  // Any of: completed word, address jump with a partial word, or end-of-download flush
  always_comb begin
    lane_sel = 4'b0001 << ioctl_addr[1:0];
    push     = (mask_q == 4'hF)
             | (ioctl_wr & (|mask_q) & (ioctl_addr[24:2] != waddr_q))
             | (dl_q & ~ioctl_download & (|mask_q));
    for (int i = 0; i < 4; i++) begin
      push_data[8*i +: 8] = mask_q[i] ? data_q[8*i +: 8] : PAD_BYTE;
    end
    mask_d  = push ? 4'h0 : mask_q;
    data_d  = data_q;
    waddr_d = waddr_q;
    if (ioctl_wr) begin
      mask_d                                = mask_d | lane_sel;
      data_d[{ioctl_addr[1:0], 3'b000} +: 8] = ioctl_data;
      waddr_d                               = ioctl_addr[24:2];
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH));
  assign fifo_wr    = push & ~fifo_full;
  assign head       = mem[rd_ptr_q[AW-1:0]];

  // Handshake: req/we rise with the head word on entry to S_REQ and hold addr/data
  // stable until a one-cycle ack is sampled; that edge pops the word and drops req.
  assign pop = (state_q == S_REQ) & sdram_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty || fifo_wr) state_d = S_REQ;
      S_REQ:   if (sdram_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign sdram_req   = (state_q == S_REQ);
  assign sdram_we    = sdram_req;
  assign sdram_addr  = sdram_req ? head[54:32] : 23'd0;
  assign sdram_data  = sdram_req ? head[31:0]  : 32'd0;
  assign busy        = ioctl_download | (|mask_q) | ~fifo_empty | sdram_req;
  assign done        = busy_q & ~busy;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q[AW-1:0]] <= {waddr_q, push_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mask_q     <= 4'h0;
      waddr_q    <= 23'd0;
      data_q     <= 32'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dl_q       <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      waddr_q    <= waddr_d;
      data_q     <= data_d;
      dl_q       <= ioctl_download;
      busy_q     <= busy;
      overflow_q <= overflow_q | (push & fifo_full);
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [15:0] cs_q, cs_d;

  // A new download restarts the sum even if its first byte lands in the same cycle
  always_comb begin
    cs_d = (ioctl_download & ~dl_q) ? 16'd0 : cs_q;
    if (ioctl_wr) cs_d = cs_d + {8'd0, ioctl_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cs_q <= 16'd0;
    else          cs_q <= cs_d;
  end

  assign checksum = cs_q;
`endif

endmodule

// File: tb/tb_rom_download_packer.sv
// Scenario bench for rom_download_packer: expected SDRAM writes are queued as bytes are
// driven and compared when the modelled controller acknowledges each request.
module tb_rom_download_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we, sdram_req;
  logic        sdram_ack = 1'b0;
  logic        busy, done, overflow;
  logic        dbg_state;
`ifdef ROM_CHECKSUM_EN
  logic [15:0] checksum;
  logic [15:0] cs_at_done;
`endif

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          ack_delay = 0;
  bit          ack_en = 1'b0;
  logic [54:0] exp_q[$];

  rom_download_packer #(.FIFO_DEPTH(4), .PAD_BYTE(8'h00)) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data),
    .sdram_we(sdram_we), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .busy(busy), .done(done), .overflow(overflow),
`ifdef ROM_CHECKSUM_EN
    .checksum(checksum),
`endif
    .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Controller model: acknowledges a held request after ack_delay extra cycles
  initial begin
    int req_cycles;
    req_cycles = 0;
    forever begin
      @(posedge clk); #1;
      if (sdram_ack) begin
        sdram_ack = 1'b0;
        req_cycles = 0;
      end else if (ack_en && sdram_req) begin
        if (req_cycles >= ack_delay) begin
          sdram_ack = 1'b1;
          req_cycles = 0;
        end else begin
          req_cycles++;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // Scoreboard: compares each acknowledged write and checks request stability
  initial begin
    logic        prev_req, prev_ack;
    logic [54:0] prev_word, w;
    prev_req = 1'b0; prev_ack = 1'b0; prev_word = '0;
    forever begin
      @(negedge clk);
      if (sdram_req && prev_req && !prev_ack) begin
        checks++;
        if ({sdram_addr, sdram_data} !== prev_word) begin
          failures++;
          $display("FAIL req_stable: got %h_%h, required %h_%h", sdram_addr, sdram_data,
                   prev_word[54:32], prev_word[31:0]);
        end
      end
      if (sdram_req && sdram_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", sdram_addr, sdram_data);
        end else begin
          w = exp_q.pop_front();
          if ({sdram_addr, sdram_data} !== w || sdram_we !== 1'b1) begin
            failures++;
            $display("FAIL write: got addr %h data %h we %b, required addr %h data %h we 1",
                     sdram_addr, sdram_data, sdram_we, w[54:32], w[31:0]);
          end
        end
      end
      if (done) begin
        done_cnt++;
`ifdef ROM_CHECKSUM_EN
        cs_at_done = checksum;
`endif
      end
      prev_req = sdram_req; prev_ack = sdram_ack; prev_word = {sdram_addr, sdram_data};
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    tick();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done_timeout: got no done pulse, required one within 300 cycles", name);
    end
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL %s_drain: got %0d pending writes and %0d done pulses, required 0 and 1",
               name, exp_q.size(), done_cnt);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    #3 reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({sdram_req, sdram_we, busy, done, overflow, sdram_addr, sdram_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req %b we %b busy %b done %b ovf %b addr %h data %h, required all 0",
               sdram_req, sdram_we, busy, done, overflow, sdram_addr, sdram_data);
    end
`ifdef ROM_CHECKSUM_EN
    checks++;
    if (checksum !== 16'h0000) begin
      failures++;
      $display("FAIL reset_checksum: got %h, required 0000", checksum);
    end
`endif
    reset_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d done pulses busy %b, required 0 and 0", done_cnt, busy);
    end
  endtask

  task automatic test_full_word_latency();
    done_cnt = 0; ack_en = 1'b1; ack_delay = 2;
    start_dl();
    exp_q.push_back({23'd0, 32'h44332211});
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    send_byte(25'd2, 8'h33);
    ioctl_addr = 25'd3; ioctl_data = 8'h44; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    @(negedge clk);
    checks++;
    if (sdram_req !== 1'b0) begin
      failures++;
      $display("FAIL latency_t1: got req %b, required 0", sdram_req);
    end
    @(negedge clk);
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 23'd0 || sdram_data !== 32'h44332211) begin
      failures++;
      $display("FAIL latency_t2: got req %b addr %h data %h, required 1 000000 44332211",
               sdram_req, sdram_addr, sdram_data);
    end
    tick();
    end_dl();
    wait_done("full_word");
  endtask

  task automatic test_partial_flush();
    done_cnt = 0; ack_en = 1'b1; ack_delay = 0;
    start_dl();
    exp_q.push_back({23'd2, 32'h0000BBAA});
    send_byte(25'd8, 8'hAA);
    send_byte(25'd9, 8'hBB);
    end_dl();
    wait_done("partial_flush");
  endtask

  task automatic test_discontinuity();
    done_cnt = 0; ack_en = 1'b1; ack_delay = 1;
    start_dl();
    exp_q.push_back({23'd1, 32'h00000055});
    exp_q.push_back({23'd5, 32'h00000066});
    send_byte(25'd4, 8'h55);
    send_byte(25'd20, 8'h66);
    end_dl();
    wait_done("discontinuity");
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    done_cnt = 0; ack_en = 1'b0;
    start_dl();
    for (int w = 0; w < 5; w++) begin
      logic [31:0] word;
      for (int l = 0; l < 4; l++) begin
        d = 8'($urandom_range(0, 255));
        word[8*l +: 8] = d;
        send_byte(25'(4*w + l), d);
      end
      if (w < 4) exp_q.push_back({23'(w), word});
    end
    repeat (3) tick();
    checks++;
    if (overflow !== 1'b1 || sdram_req !== 1'b1 || sdram_addr !== 23'd0) begin
      failures++;
      $display("FAIL overflow_set: got ovf %b req %b addr %h, required 1 1 000000",
               overflow, sdram_req, sdram_addr);
    end
    ack_en = 1'b1; ack_delay = 0;
    end_dl();
    wait_done("overflow");
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: got %b, required 1", overflow);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit stray;
    done_cnt = 0; ack_en = 1'b0;
    start_dl();
    for (int l = 0; l < 4; l++) send_byte(25'h100 + 25'(l), 8'(l + 1));
    end_dl();
    n = 0;
    while (sdram_req !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (sdram_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_req: got req %b, required 1 before reset", sdram_req);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (sdram_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got req %b busy %b done %b ovf %b, required 0 0 0 0",
               sdram_req, busy, done, overflow);
    end
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    ack_en = 1'b1;
    stray = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (sdram_req !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    tick();
    checks++;
    if (stray || done_cnt != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: got activity %b done pulses %0d, required 0 and 0", stray, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] cur;
    logic [31:0] word;
    logic [7:0]  d;
    int          nl;
    done_cnt = 0; ack_en = 1'b1; ack_delay = $urandom_range(0, 1);
    start_dl();
    cur = 23'h7FFFC0;
    for (int w = 0; w < 12; w++) begin
      nl = $urandom_range(2, 4);
      word = 32'h0;
      if ($urandom_range(0, 1) == 1) send_byte({cur, 2'd0}, 8'hEE);
      for (int l = 0; l < nl; l++) begin
        d = 8'($urandom_range(0, 255));
        word[8*l +: 8] = d;
        if (l == 0) exp_q.push_back({cur, 32'h0});
        send_byte({cur, 2'(l)}, d);
      end
      exp_q[exp_q.size() - 1] = {cur, word};
      cur = cur + 23'($urandom_range(1, 3));
    end
    end_dl();
    wait_done("back_to_back");
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_overflow: got %b, required 0", overflow);
    end
  endtask

`ifdef ROM_CHECKSUM_EN
  task automatic test_checksum();
    done_cnt = 0; ack_en = 1'b1; ack_delay = 0;
    start_dl();
    exp_q.push_back({23'd0, 32'h0002FFFF});
    send_byte(25'd0, 8'hFF);
    send_byte(25'd1, 8'hFF);
    send_byte(25'd2, 8'h02);
    end_dl();
    wait_done("checksum");
    checks++;
    if (cs_at_done !== 16'h0200) begin
      failures++;
      $display("FAIL checksum: got %h at done, required 0200", cs_at_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_word_latency();
    test_partial_flush();
    test_discontinuity();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
`ifdef ROM_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
